// File: rtl/nes_pkg.sv
// Shared NES definitions used by the OAM DMA engine.
//   DMA_TRIG_ADDR : CPU address whose store starts a sprite DMA
//   PPU_OAMDATA   : PPU register index receiving each DMA byte
//   PAGE_BYTES    : bytes moved per DMA
//   dma_state_t   : OAM DMA sequencer states
package nes_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [2:0]  PPU_OAMDATA   = 3'd4;
    localparam int          PAGE_BYTES    = 256;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine. A CPU store to $4014 halts the CPU (rdy=0) and
// copies CPU page $XX00-$XXFF into PPU OAMDATA, one byte per READ/WRITE
// pair of CPU cycles. Every state step happens on a CLOCK_50 edge with
// cpu_ce=1, so one step is one CPU cycle.
//
// Ports:
//   CLOCK_50, reset            clock, async active-high reset
//   cpu_ce                     one-clock pulse per CPU cycle
//   cpu_addr/cpu_we/cpu_data_out  CPU bus, used to detect the trigger
//   rdy, dma_active            CPU halt and busy flags
//   mem_addr, mem_rd, mem_data_in DMA read side of the CPU memory bus
//   ppu_reg_cs/ppu_reg_addr/ppu_we/ppu_data  PPU register write port
//
// state | meaning
// IDLE  | waiting for a $4014 store, CPU running
// HALT  | first dummy cycle after the trigger
// ALIGN | extra dummy cycle when the halt lands on an odd cycle
// READ  | reading byte {page,idx} from CPU memory
// WRITE | writing the captured byte to OAMDATA
module oam_dma
    import nes_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_data_out,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_reg_cs,
    output logic [2:0]  ppu_reg_addr,
    output logic        ppu_we,
    output logic [7:0]  ppu_data
);

    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

    dma_state_t state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] idx_next;

    assign idx_next = idx + 8'd1;

    // ppu_data doubles as the captured-byte register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            parity       <= 1'b0;
            page         <= 8'd0;
            idx          <= 8'd0;
            rdy          <= 1'b1;
            dma_active   <= 1'b0;
            mem_addr     <= 16'd0;
            mem_rd       <= 1'b0;
            ppu_reg_cs   <= 1'b0;
            ppu_reg_addr <= 3'd0;
            ppu_we       <= 1'b0;
            ppu_data     <= 8'd0;
        end else if (cpu_ce) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_we && cpu_addr == DMA_TRIG_ADDR) begin
                        page       <= cpu_data_out;
                        idx        <= 8'd0;
                        rdy        <= 1'b0;
                        dma_active <= 1'b1;
                        state      <= HALT;
                    end
                end
                HALT: begin
                    if (parity) begin
                        state <= ALIGN;
                    end else begin
                        mem_addr <= {page, idx};
                        mem_rd   <= 1'b1;
                        state    <= READ;
                    end
                end
                ALIGN: begin
                    mem_addr <= {page, idx};
                    mem_rd   <= 1'b1;
                    state    <= READ;
                end
                READ: begin
                    ppu_data     <= mem_data_in;
                    mem_rd       <= 1'b0;
                    ppu_reg_cs   <= 1'b1;
                    ppu_reg_addr <= PPU_OAMDATA;
                    ppu_we       <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    ppu_reg_cs   <= 1'b0;
                    ppu_reg_addr <= 3'd0;
                    ppu_we       <= 1'b0;
                    idx          <= idx_next;
                    if (idx == LAST_IDX) begin
                        rdy        <= 1'b1;
                        dma_active <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        // Page concatenation keeps the address inside the page.
                        mem_addr <= {page, idx_next};
                        mem_rd   <= 1'b1;
                        state    <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_data_out;
    logic        rdy;
    logic        dma_active;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_in;
    logic        ppu_reg_cs;
    logic [2:0]  ppu_reg_addr;
    logic        ppu_we;
    logic [7:0]  ppu_data;

    int total = 0;
    int bad   = 0;
    int ce_count = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    // Memory model: low address byte XOR A5, so $XX00+i holds i^A5.
    assign mem_data_in = mem_addr[7:0] ^ 8'hA5;

    oam_dma dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .cpu_ce       (cpu_ce),
        .cpu_addr     (cpu_addr),
        .cpu_we       (cpu_we),
        .cpu_data_out (cpu_data_out),
        .rdy          (rdy),
        .dma_active   (dma_active),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data_in  (mem_data_in),
        .ppu_reg_cs   (ppu_reg_cs),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_we       (ppu_we),
        .ppu_data     (ppu_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: cpu_ce high for exactly one CLOCK_50 edge.
    task automatic ce_pulse(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge CLOCK_50);
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = a; cpu_data_out = d;
        @(posedge CLOCK_50);
        ce_count++;
        #1;
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
    endtask

    // Trigger a DMA from page pg and follow it cycle by cycle. The expected
    // length comes from the bench's own count of cpu_ce pulses since reset:
    // the parity register seen at the HALT step equals (pulses before the
    // trigger + 1) mod 2, and an odd value adds the ALIGN cycle.
    task automatic run_dma(input logic [7:0] pg, input int retrig_at,
                           input int gate_at, input int stop_at);
        int n, writes, reads, first_rd, exp_len, exp_first;
        bit retrig_done, gate_done;
        logic [33:0] snap;
        exp_len   = (ce_count % 2 == 0) ? 514 : 513;
        exp_first = (exp_len == 514) ? 2 : 1;
        n = 0; writes = 0; reads = 0; first_rd = -1;
        retrig_done = 0; gate_done = 0;
        ce_pulse(1'b1, 16'h4014, pg);
        chk("trig_rdy", 32'(rdy), 32'd0);
        chk("trig_active", 32'(dma_active), 32'd1);
        while (n < 700) begin
            if (stop_at >= 0 && writes == stop_at) return;
            if (gate_at >= 0 && writes == gate_at && !gate_done) begin
                gate_done = 1;
                snap = {rdy, dma_active, mem_addr, mem_rd, ppu_reg_cs, ppu_reg_addr, ppu_we, ppu_data};
                cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data_out = 8'h07;
                repeat (10) @(posedge CLOCK_50);
                #1;
                cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
                chk("gate_frozen", 32'(snap), 32'({rdy, dma_active, mem_addr, mem_rd,
                    ppu_reg_cs, ppu_reg_addr, ppu_we, ppu_data}));
            end
            if (retrig_at >= 0 && writes == retrig_at && !retrig_done) begin
                retrig_done = 1;
                ce_pulse(1'b1, 16'h4014, 8'h05);
            end else begin
                ce_pulse(1'b0, 16'h0000, 8'h00);
            end
            n++;
            if (mem_rd) begin
                if (first_rd < 0) first_rd = n;
                if (mem_addr !== {pg, 8'(reads)} || ppu_we)
                    chk("rd_addr", 32'({ppu_we, mem_addr}), 32'({1'b0, pg, 8'(reads)}));
                reads++;
            end
            if (ppu_we) begin
                if (ppu_data !== (8'(writes) ^ 8'hA5) || ppu_reg_addr !== 3'd4 || !ppu_reg_cs)
                    chk("wr_data", 32'({ppu_reg_cs, ppu_reg_addr, ppu_data}),
                        32'({1'b1, 3'd4, 8'(writes) ^ 8'hA5}));
                writes++;
            end
            if (rdy) break;
        end
        chk("len", 32'(n), 32'(exp_len));
        chk("writes", 32'(writes), 32'd256);
        chk("reads", 32'(reads), 32'd256);
        chk("first_rd", 32'(first_rd), 32'(exp_first));
        chk("end_active", 32'(dma_active), 32'd0);
        chk("end_we", 32'({ppu_we, ppu_reg_cs, mem_rd}), 32'd0);
        chk("last_addr", 32'(mem_addr), 32'({pg, 8'hFF}));
    endtask

    initial begin
        reset = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h0000; cpu_data_out = 8'h00;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_outs", 32'({dma_active, mem_addr, mem_rd, ppu_reg_cs, ppu_reg_addr, ppu_we, ppu_data}), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        ce_count = 0;

        // Writes elsewhere must not trigger.
        ce_pulse(1'b1, 16'h4015, 8'h02);
        chk("no_trig", 32'({rdy, dma_active}), 32'b10);

        // ce_count=1 -> HALT-step parity 0 -> 513 cycles.
        run_dma(8'h02, -1, -1, -1);

        // ce_count odd after the run; one idle pulse makes it even -> 514.
        ce_pulse(1'b0, 16'h0000, 8'h00);
        run_dma(8'h02, -1, -1, -1);

        run_dma(8'hFF, -1, -1, -1);

        run_dma(8'h02, 100, -1, -1);

        run_dma(8'h02, -1, 50, -1);

        // Reset during byte 37.
        run_dma(8'h02, -1, -1, 37);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        chk("mid_rst_outs", 32'({dma_active, mem_rd, ppu_reg_cs, ppu_we}), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        ce_count = 0;
        ce_pulse(1'b0, 16'h0000, 8'h00);
        run_dma(8'h03, -1, -1, -1);

        // Trigger and reset on the same edge: reset wins.
        @(negedge CLOCK_50);
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data_out = 8'h04;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("rst_wins", 32'({rdy, dma_active}), 32'b10);
        cpu_ce = 1'b0; cpu_we = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        ce_pulse(1'b0, 16'h0000, 8'h00);
        chk("rst_wins_idle", 32'({rdy, dma_active}), 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
